synaptic_update_ctrl: RTL and testbench
=======================================

SYNAPTIC_UPDATE_CTRL -- requirements
Module: synaptic_update_ctrl

Interface
REQ-001 SHALL have parameter N_PRE, default 256, meaning presynaptic rows per post-neuron pass (power of two, >= 4).
REQ-002 SHALL have parameter NEUR_W, default 8, meaning post-neuron index width.
REQ-003 SHALL derive PRE_W = clog2(N_PRE) and ADDR_W = NEUR_W + PRE_W.
REQ-004 SHALL have port CLK, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port START, input, 1, one-cycle pass request.
REQ-007 SHALL have port ABORT, input, 1, cancel request for the current pass.
REQ-008 SHALL have port POST_IDX, input, NEUR_W, post-neuron index, latched on START acceptance.
REQ-009 SHALL have port IS_TRAIN_IN, input, 1, pass mode, latched on START acceptance.
REQ-010 SHALL have port SRAM_RE, output, 1, synapse SRAM read enable.
REQ-011 SHALL have port SRAM_RADDR, output, ADDR_W, read address {POST_IDX, pre_idx}.
REQ-012 SHALL have port SRAM_WE, output, 1, write enable for weight/gradient write-back.
REQ-013 SHALL have port SRAM_WADDR, output, ADDR_W, write-back address.
REQ-014 SHALL have port CTRL_TREF_EVENT, output, 1, update strobe to the weight-update stage.
REQ-015 SHALL have port IS_TRAIN, output, 1, latched mode to the weight-update stage.
REQ-016 SHALL have ports BUSY, output, 1, pass in progress; and DONE, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on accepted START, READ->DRAIN after the read of pre_idx N_PRE-1 or on ABORT, DRAIN->IDLE when no write-back remains.
REQ-018 SHALL accept START only in IDLE with ABORT low; START in READ/DRAIN SHALL be ignored.
REQ-019 SHALL, START accepted in cycle 0, assert SRAM_RE in cycles 1..N_PRE with pre_idx 0..N_PRE-1, one per cycle, no gaps.
REQ-020 SHALL assert SRAM_WE with SRAM_WADDR equal to the address read two cycles earlier (1-cycle SRAM latency plus 1 update-stage register); last write in cycle N_PRE+2.
REQ-021 SHALL drive CTRL_TREF_EVENT identical to SRAM_WE every cycle.
REQ-022 SHALL assert BUSY from cycle 1 through the last SRAM_WE cycle inclusive; DONE SHALL pulse in the cycle after the last SRAM_WE with BUSY low.
REQ-023 SHALL, on ABORT in READ, issue no further reads from that cycle, complete in-flight write-backs (at most 2), return to IDLE and not pulse DONE.
REQ-024 SHALL ignore ABORT in IDLE and DRAIN; ABORT and START together in IDLE SHALL not start a pass.
REQ-025 SHALL hold SRAM_RADDR/SRAM_WADDR at last value when the respective enable is low; pre_idx SHALL not wrap into a second pass.
REQ-026 SHALL rely on dual-port SRAM; simultaneous read of pre_idx k+2 and write of pre_idx k is legal.

Reset
REQ-027 SHALL, with RST_N low, force state IDLE and all outputs 0 immediately, including mid-pass; in-flight write-backs SHALL be discarded.
REQ-028 SHALL resume START acceptance on the first rising CLK edge after RST_N deasserts.

Configuration
REQ-029 SHALL, with macro SYNUPD_PASS_CNT_EN defined, add output PASS_CNT (16 bits, reset 0) counting DONE pulses, saturating at 65535, not incremented by aborted passes.
REQ-030 SHALL, without SYNUPD_PASS_CNT_EN, omit PASS_CNT and its counter; all other behaviour identical.

Verification
REQ-031 SHALL cover: N_PRE=4, POST_IDX=3, START cycle 0 -> RE addrs 12,13,14,15 cycles 1-4; WE addrs 12-15 cycles 3-6; DONE cycle 7.
REQ-032 SHALL cover: START again in cycle 2 of a pass -> ignored, sequence of REQ-031 unchanged, one DONE.
REQ-033 SHALL cover: ABORT in cycle 2 (N_PRE=4) -> reads at 12 only in cycle 1, WE for 12 in cycle 3, BUSY low cycle 4, no DONE.
REQ-034 SHALL cover: RST_N low in cycle 3 -> all outputs 0 same cycle; START after release -> fresh pass from pre_idx 0.
REQ-035 SHALL cover: IS_TRAIN_IN=1 at START, toggled during pass -> IS_TRAIN stays 1 until IDLE.
REQ-036 SHALL cover (SYNUPD_PASS_CNT_EN): 3 complete passes plus 1 aborted -> PASS_CNT=3; preload 65535 -> stays 65535.

Source files
------------

// File: rtl/synaptic_update_ctrl.sv
// Synapse SRAM sweep controller: reads N_PRE rows for one post-neuron and issues write-backs two cycles later.
// Optional macro SYNUPD_PASS_CNT_EN adds a saturating PASS_CNT output counting completed passes.
module synaptic_update_ctrl #(
  parameter  int N_PRE  = 256,
  parameter  int NEUR_W = 8,
  localparam int PRE_W  = $clog2(N_PRE),
  localparam int ADDR_W = NEUR_W + PRE_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [NEUR_W-1:0] POST_IDX,
  input  logic              IS_TRAIN_IN,
  output logic              SRAM_RE,
  output logic [ADDR_W-1:0] SRAM_RADDR,
  output logic              SRAM_WE,
  output logic [ADDR_W-1:0] SRAM_WADDR,
  output logic              CTRL_TREF_EVENT,
  output logic              IS_TRAIN,
  output logic              BUSY,
  output logic              DONE
`ifdef SYNUPD_PASS_CNT_EN
  ,
  output logic [15:0]       PASS_CNT
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(N_PRE - 1);

  state_t              state_q;
  logic [PRE_W-1:0]    pre_q;
  logic [NEUR_W-1:0]   post_q;
  logic                train_q;
  logic                aborted_q;
  logic                done_q;
  logic                rd_v1_q;
  logic [ADDR_W-1:0]   rd_a1_q;
  logic [ADDR_W-1:0]   last_raddr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;

  logic                rd_d;
  logic [ADDR_W-1:0]   raddr_d;
  logic                pass_end_d;

  // ABORT suppresses the read in the very cycle it arrives, so the enable is gated combinationally.
  assign rd_d       = (state_q == S_READ) && !ABORT;
  assign raddr_d    = {post_q, pre_q};
  assign pass_end_d = (state_q == S_DRAIN) && !rd_v1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      post_q       <= '0;
      train_q      <= 1'b0;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
      rd_v1_q      <= 1'b0;
      rd_a1_q      <= '0;
      last_raddr_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_v1_q <= rd_d;
      if (rd_d) begin
        rd_a1_q      <= raddr_d;
        last_raddr_q <= raddr_d;
      end
      we_q <= rd_v1_q;
      if (rd_v1_q) waddr_q <= rd_a1_q;

      case (state_q)
        S_IDLE: begin
          if (START && !ABORT) begin
            state_q   <= S_READ;
            pre_q     <= '0;
            post_q    <= POST_IDX;
            train_q   <= IS_TRAIN_IN;
            aborted_q <= 1'b0;
          end
        end
        S_READ: begin
          if (ABORT) begin
            state_q   <= S_DRAIN;
            aborted_q <= 1'b1;
          end else if (pre_q == PRE_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
        S_DRAIN: begin
          // The last write-back is already in we_q once nothing is left in the read stage.
          if (!rd_v1_q) begin
            state_q <= S_IDLE;
            train_q <= 1'b0;
            done_q  <= !aborted_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SYNUPD_PASS_CNT_EN
  logic [15:0] pass_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pass_cnt_q <= '0;
    end else if (pass_end_d && !aborted_q && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_q <= pass_cnt_q + 16'd1;
    end
  end

  assign PASS_CNT = pass_cnt_q;
`else
  logic unused_pass_end;
  assign unused_pass_end = pass_end_d;
`endif

  assign SRAM_RE         = rd_d;
  assign SRAM_RADDR      = rd_d ? raddr_d : last_raddr_q;
  assign SRAM_WE         = we_q;
  assign SRAM_WADDR      = waddr_q;
  assign CTRL_TREF_EVENT = we_q;
  assign IS_TRAIN        = train_q;
  assign BUSY            = (state_q != S_IDLE);
  assign DONE            = done_q;

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Bench for synaptic_update_ctrl (N_PRE=4): directed scenarios then random traffic, checked per cycle
// against a pass-level reference model.
module tb_synaptic_update_ctrl;

  localparam int N  = 4;
  localparam int NW = 8;
  localparam int AW = NW + 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          START;
  logic          ABORT;
  logic [NW-1:0] POST_IDX;
  logic          IS_TRAIN_IN;
  logic          SRAM_RE;
  logic [AW-1:0] SRAM_RADDR;
  logic          SRAM_WE;
  logic [AW-1:0] SRAM_WADDR;
  logic          CTRL_TREF_EVENT;
  logic          IS_TRAIN;
  logic          BUSY;
  logic          DONE;
`ifdef SYNUPD_PASS_CNT_EN
  logic [15:0]   PASS_CNT;
`endif

  synaptic_update_ctrl #(.N_PRE(N), .NEUR_W(NW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .POST_IDX(POST_IDX), .IS_TRAIN_IN(IS_TRAIN_IN),
    .SRAM_RE(SRAM_RE), .SRAM_RADDR(SRAM_RADDR),
    .SRAM_WE(SRAM_WE), .SRAM_WADDR(SRAM_WADDR),
    .CTRL_TREF_EVENT(CTRL_TREF_EVENT), .IS_TRAIN(IS_TRAIN),
    .BUSY(BUSY), .DONE(DONE)
`ifdef SYNUPD_PASS_CNT_EN
    , .PASS_CNT(PASS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a pass is "k cycles since START" plus the k at which ABORT landed (0 = none).
  bit          m_act  = 0;
  int          m_k    = 0;
  int          m_a    = 0;
  logic [NW-1:0] m_post = '0;
  logic        m_train = 0;
  logic [AW-1:0] m_lr = '0;
  logic [AW-1:0] m_lw = '0;
  logic        m_done = 0;
  int          m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic [NW-1:0] pi,
                      input logic tr, input logic rn);
    logic e_re, e_we, e_busy, e_train, e_done;
    int   e_cnt, rk, end_k;
    START = st; ABORT = ab; POST_IDX = pi; IS_TRAIN_IN = tr; RST_N = rn;
    @(negedge CLK);
    e_re = 0; e_we = 0; e_busy = 0; e_train = 0; e_done = 0;
    if (!rn) begin
      m_act = 0; m_lr = '0; m_lw = '0; m_done = 0; m_cnt = 0;
      e_cnt = 0;
    end else if (m_act) begin
      e_cnt = m_cnt;
      if (ab && m_a == 0 && m_k <= N) m_a = m_k;
      e_re = (m_a == 0) && (m_k <= N);
      rk   = m_k - 2;
      e_we = (rk >= 1) && (rk <= N) && (m_a == 0 || rk < m_a);
      if (e_re) m_lr = {m_post, 2'(m_k - 1)};
      if (e_we) m_lw = {m_post, 2'(rk - 1)};
      e_busy  = 1;
      e_train = m_train;
      end_k   = (m_a != 0) ? m_a + 1 : N + 2;
      if (m_k >= end_k) begin
        m_act  = 0;
        m_done = (m_a == 0);
        if (m_done && m_cnt < 65535) m_cnt++;
      end else begin
        m_k++;
      end
    end else begin
      e_cnt  = m_cnt;
      e_done = m_done;
      m_done = 0;
      if (st && !ab) begin
        m_act = 1; m_k = 1; m_a = 0; m_post = pi; m_train = tr;
      end
    end
    chk("re",       32'(SRAM_RE),         32'(e_re));
    chk("raddr",    32'(SRAM_RADDR),      32'(m_lr));
    chk("we",       32'(SRAM_WE),         32'(e_we));
    chk("waddr",    32'(SRAM_WADDR),      32'(m_lw));
    chk("tref",     32'(CTRL_TREF_EVENT), 32'(e_we));
    chk("is_train", 32'(IS_TRAIN),        32'(e_train));
    chk("busy",     32'(BUSY),            32'(e_busy));
    chk("done",     32'(DONE),            32'(e_done));
`ifdef SYNUPD_PASS_CNT_EN
    chk("pass_cnt", 32'(PASS_CNT),        32'(e_cnt));
`endif
    @(posedge CLK); #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 1);
  endtask

  initial begin
    RST_N = 0; START = 0; ABORT = 0; POST_IDX = '0; IS_TRAIN_IN = 0;
    @(posedge CLK); #1;
    step(0, 0, '0, 0, 0);
    step(1, 0, 8'd5, 1, 0);
    idle_n(2);

    // Basic pass, POST_IDX=3: reads 12..15, writes 12..15, DONE after.
    step(1, 0, 8'd3, 0, 1);
    idle_n(8);

    // Second START mid-pass is ignored.
    step(1, 0, 8'd3, 0, 1);
    step(0, 0, 8'd3, 0, 1);
    step(1, 0, 8'd9, 1, 1);
    idle_n(7);

    // ABORT in cycle 2.
    step(1, 0, 8'd3, 0, 1);
    step(0, 0, 8'd3, 0, 1);
    step(0, 1, 8'd3, 0, 1);
    idle_n(4);

    // START together with ABORT in IDLE does not start; ABORT in DRAIN is ignored.
    step(1, 1, 8'd7, 0, 1);
    step(1, 0, 8'd7, 0, 1);
    for (int i = 0; i < 5; i++) step(0, (i == 4), 8'd7, 0, 1);
    idle_n(3);

    // Reset mid-pass, then a fresh pass starts on the first edge after release.
    step(1, 0, 8'd3, 1, 1);
    step(0, 0, 8'd3, 1, 1);
    step(0, 0, 8'd3, 1, 1);
    step(0, 0, 8'd3, 1, 0);
    step(1, 0, 8'd2, 0, 1);
    idle_n(8);

    // Mode latched at START survives toggling of IS_TRAIN_IN.
    step(1, 0, 8'd1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 8'd1, 1'(i), 1);

`ifdef SYNUPD_PASS_CNT_EN
    step(0, 0, '0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      step(1, 0, 8'(p), 0, 1);
      idle_n(7);
    end
    step(1, 0, 8'd4, 0, 1);
    step(0, 1, 8'd4, 0, 1);
    idle_n(4);
    chk("pass_cnt_3", 32'(PASS_CNT), 32'd3);
`endif

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0),
           NW'($urandom),
           1'($urandom),
           ($urandom_range(0, 149) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
